// File: rtl/latch_bank_wr_ctrl.sv
// Write-side sequencer for a latch-based register file.
// Each write is sequenced SETUP -> OPEN -> HOLD so the data bus is stable around the gate pulse.
module latch_bank_wr_ctrl #(
  parameter int WORDS = 8,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             WR_VALID,
  output logic             WR_READY,
  input  logic [AW-1:0]    WR_ADDR,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic [WIDTH-1:0] LD,
  output logic [WORDS-1:0] LG,
  output logic             BUSY,
  output logic             ERR
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_OPEN  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [AW:0] WORDS_L = (AW+1)'(WORDS);

  state_t           r_state;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_ld;
  logic [WORDS-1:0] r_lg;
  logic             r_busy;
  logic             r_ready;
  logic             r_err;

  logic [WORDS-1:0] w_onehot;
  logic             w_accept;
  logic             w_in_range;

  // r_ready mirrors (state == IDLE || state == HOLD) exactly, so acceptance depends on state only.
  assign w_accept   = WR_VALID && r_ready;
  assign w_in_range = ({1'b0, WR_ADDR} < WORDS_L);

  // An out-of-range captured address matches no bit, so the gate stays closed for it.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_onehot
      assign w_onehot[gi] = (r_addr == AW'(gi));
    end
  endgenerate

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_ld    <= '0;
      r_lg    <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      r_lg  <= '0;
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_accept) begin
            r_state <= S_SETUP;
            r_addr  <= WR_ADDR;
            r_ld    <= WR_DATA;
            r_err   <= !w_in_range;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        S_SETUP: begin
          r_state <= S_OPEN;
          r_lg    <= w_onehot;
          r_busy  <= 1'b1;
          r_ready <= 1'b0;
        end
        S_OPEN: begin
          r_state <= S_HOLD;
          r_busy  <= 1'b1;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign WR_READY = r_ready;
  assign LD       = r_ld;
  assign LG       = r_lg;
  assign BUSY     = r_busy;
  assign ERR      = r_err;

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Directed bench for latch_bank_wr_ctrl: an 8-word instance with a behavioural latch bank,
// plus a 6-word instance for the out-of-range address case.
module tb_latch_bank_wr_ctrl;

  logic       CK;
  logic       RST;
  logic       ck_run;

  logic       WR_VALID;
  logic       WR_READY;
  logic [2:0] WR_ADDR;
  logic [7:0] WR_DATA;
  logic [7:0] LD;
  logic [7:0] LG;
  logic       BUSY;
  logic       ERR;

  logic       v6;
  logic       rdy6;
  logic [2:0] a6;
  logic [7:0] d6;
  logic [7:0] ld6;
  logic [5:0] lg6;
  logic       busy6;
  logic       err6;

  int n_checks;
  int n_fail;

  logic [7:0] bank [8];

  latch_bank_wr_ctrl #(.WORDS(8), .WIDTH(8)) dut (
    .CK(CK), .RST(RST), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .LD(LD), .LG(LG), .BUSY(BUSY), .ERR(ERR)
  );

  latch_bank_wr_ctrl #(.WORDS(6), .WIDTH(8)) dut6 (
    .CK(CK), .RST(RST), .WR_VALID(v6), .WR_READY(rdy6),
    .WR_ADDR(a6), .WR_DATA(d6), .LD(ld6), .LG(lg6), .BUSY(busy6), .ERR(err6)
  );

  // Clock can be held low so reset is observed with no edges at all.
  initial CK = 1'b0;
  always begin
    #5;
    if (ck_run) CK = ~CK;
  end

  // Behavioural high-transparent latches.
  always @(LG or LD) begin
    for (int i = 0; i < 8; i++)
      if (LG[i] === 1'b1) bank[i] = LD;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ck_run   = 1'b0;
    RST      = 1'b0;
    WR_VALID = 1'b0;
    WR_ADDR  = '0;
    WR_DATA  = '0;
    v6       = 1'b0;
    a6       = '0;
    d6       = '0;
    for (int i = 0; i < 8; i++) bank[i] = 8'hE0 + 8'(i);

    // Reset with the clock stopped
    #3 RST = 1'b1;
    #1;
    chk("rst_LG", LG, 8'h00);
    chk("rst_LD", LD, 8'h00);
    chk("rst_BUSY", BUSY, 1'b0);
    chk("rst_READY", WR_READY, 1'b1);
    chk("rst_ERR", ERR, 1'b0);
    chk("rst6_READY", rdy6, 1'b1);

    ck_run = 1'b1;
    tick;
    tick;
    RST = 1'b0;
    tick;
    chk("idle_BUSY", BUSY, 1'b0);

    // Single write 0xA5 -> word 3
    WR_VALID = 1'b1; WR_ADDR = 3'd3; WR_DATA = 8'hA5;
    tick;
    WR_VALID = 1'b0;
    chk("sw_E0_LD", LD, 8'hA5);
    chk("sw_E0_LG", LG, 8'h00);
    chk("sw_E0_BUSY", BUSY, 1'b1);
    chk("sw_E0_READY", WR_READY, 1'b0);
    tick;
    chk("sw_E1_LG", LG, 8'h08);
    chk("sw_E1_READY", WR_READY, 1'b0);
    tick;
    chk("sw_E2_LG", LG, 8'h00);
    chk("sw_E2_LD", LD, 8'hA5);
    chk("sw_E2_READY", WR_READY, 1'b1);
    chk("sw_E2_BUSY", BUSY, 1'b1);
    tick;
    chk("sw_E3_BUSY", BUSY, 1'b0);
    chk("sw_bank3", bank[3], 8'hA5);
    chk("sw_bank2", bank[2], 8'hE2);
    chk("sw_bank4", bank[4], 8'hE4);

    // Back-to-back: 0/0x11, 7/0x77, 2/0x22
    WR_VALID = 1'b1; WR_ADDR = 3'd0; WR_DATA = 8'h11;
    tick;
    chk("bb0_LD", LD, 8'h11);
    chk("bb0_READY", WR_READY, 1'b0);
    WR_ADDR = 3'd7; WR_DATA = 8'h77;
    tick;
    chk("bb1_LG", LG, 8'h01);
    chk("bb1_LD", LD, 8'h11);
    chk("bb1_READY", WR_READY, 1'b0);
    tick;
    chk("bb2_LG", LG, 8'h00);
    chk("bb2_LD", LD, 8'h11);
    chk("bb2_READY", WR_READY, 1'b1);
    tick;
    chk("bb3_LD", LD, 8'h77);
    chk("bb3_LG", LG, 8'h00);
    chk("bb3_BUSY", BUSY, 1'b1);
    WR_ADDR = 3'd2; WR_DATA = 8'h22;
    tick;
    chk("bb4_LG", LG, 8'h80);
    chk("bb4_LD", LD, 8'h77);
    tick;
    chk("bb5_LG", LG, 8'h00);
    tick;
    chk("bb6_LD", LD, 8'h22);
    WR_VALID = 1'b0;
    tick;
    chk("bb7_LG", LG, 8'h04);
    chk("bb7_LD", LD, 8'h22);
    tick;
    chk("bb8_LG", LG, 8'h00);
    tick;
    chk("bb9_BUSY", BUSY, 1'b0);
    chk("bb9_LD_retained", LD, 8'h22);
    chk("bb_bank0", bank[0], 8'h11);
    chk("bb_bank7", bank[7], 8'h77);
    chk("bb_bank2", bank[2], 8'h22);
    chk("bb_bank3", bank[3], 8'hA5);

    // Stall: new request presented during SETUP waits for HOLD
    WR_VALID = 1'b1; WR_ADDR = 3'd1; WR_DATA = 8'h3C;
    tick;
    WR_ADDR = 3'd6; WR_DATA = 8'h66;
    tick;
    chk("st_E1_LG", LG, 8'h02);
    chk("st_E1_LD", LD, 8'h3C);
    tick;
    chk("st_E2_LD", LD, 8'h3C);
    chk("st_E2_READY", WR_READY, 1'b1);
    tick;
    WR_VALID = 1'b0;
    chk("st_E3_LD", LD, 8'h66);
    chk("st_E3_BUSY", BUSY, 1'b1);
    tick;
    chk("st_E4_LG", LG, 8'h40);
    tick;
    tick;
    chk("st_done_BUSY", BUSY, 1'b0);
    chk("st_bank1", bank[1], 8'h3C);
    chk("st_bank6", bank[6], 8'h66);

    // Out-of-range on the 6-word instance
    v6 = 1'b1; a6 = 3'd6; d6 = 8'h5A;
    tick;
    v6 = 1'b0;
    chk("oor_E0_ERR", err6, 1'b1);
    chk("oor_E0_LG", lg6, 6'h00);
    chk("oor_E0_LD", ld6, 8'h5A);
    chk("oor_E0_BUSY", busy6, 1'b1);
    tick;
    chk("oor_E1_ERR", err6, 1'b0);
    chk("oor_E1_LG", lg6, 6'h00);
    chk("oor_E1_BUSY", busy6, 1'b1);
    tick;
    chk("oor_E2_LG", lg6, 6'h00);
    chk("oor_E2_BUSY", busy6, 1'b1);
    tick;
    chk("oor_E3_BUSY", busy6, 1'b0);
    chk("oor_E3_ERR", err6, 1'b0);
    v6 = 1'b1; a6 = 3'd5; d6 = 8'hC3;
    tick;
    v6 = 1'b0;
    chk("w6_E0_ERR", err6, 1'b0);
    tick;
    chk("w6_E1_LG", lg6, 6'h20);
    tick;
    tick;

    // Reset during OPEN, then a request held during reset
    WR_VALID = 1'b1; WR_ADDR = 3'd1; WR_DATA = 8'h99;
    tick;
    WR_VALID = 1'b0;
    tick;
    chk("rm_E1_LG", LG, 8'h02);
    #2 RST = 1'b1;
    #1;
    chk("rm_async_LG", LG, 8'h00);
    chk("rm_async_LD", LD, 8'h00);
    chk("rm_async_BUSY", BUSY, 1'b0);
    chk("rm_async_READY", WR_READY, 1'b1);
    WR_VALID = 1'b1; WR_ADDR = 3'd5; WR_DATA = 8'h55;
    tick;
    chk("rm_inrst_BUSY", BUSY, 1'b0);
    chk("rm_inrst_LD", LD, 8'h00);
    @(negedge CK);
    RST = 1'b0;
    tick;
    WR_VALID = 1'b0;
    chk("rm_E0_LD", LD, 8'h55);
    chk("rm_E0_BUSY", BUSY, 1'b1);
    tick;
    chk("rm_E1_LG5", LG, 8'h20);
    tick;
    chk("rm_E2_LG", LG, 8'h00);
    tick;
    chk("rm_E3_BUSY", BUSY, 1'b0);
    chk("rm_bank5", bank[5], 8'h55);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/latch_bank_wr_ctrl.md
# latch_bank_wr_ctrl

- Write-side controller that sits directly upstream of a bank of high-transparent D latches (DLH_X2 cells) forming a latch-based register file.
- Accepts write requests over a valid/ready handshake and drives the shared latch data bus and one-hot per-word latch gates.
- Sequences every write as SETUP → OPEN → HOLD, so the latches see data stable before their gate rises and after it falls.
- All outputs are glitch-free flop outputs.

## Interface
Parameters:
- WORDS, 8: number of latch words in the bank (2..64).
- WIDTH, 8: bits per word.
- AW, $clog2(WORDS): address width (derived; do not override).

Ports:
- CK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset; asynchronous, active-high.
- WR_VALID  input  1  write request present.
- WR_READY  output  1  controller can accept a request this cycle.
- WR_ADDR  input  AW  target word index.
- WR_DATA  input  WIDTH  write data.
- LD  output  WIDTH  shared data bus to every latch D pin.
- LG  output  WORDS  one-hot latch gate enables (G pins); at most one bit high.
- BUSY  output  1  high whenever state ≠ IDLE.
- ERR  output  1  one-cycle pulse: accepted request had WR_ADDR ≥ WORDS.

## Operation
- States: IDLE, SETUP, OPEN, HOLD. Registered: state, addr, data, LD, LG, ERR.
- A request is accepted on a rising CK edge when WR_VALID && WR_READY. WR_ADDR and WR_DATA are captured on that edge.
- WR_READY = (state == IDLE) || (state == HOLD). It is combinational from state only and does not depend on WR_VALID.
- Transitions:
  - IDLE: accept → SETUP; else stay.
  - SETUP → OPEN unconditionally.
  - OPEN → HOLD unconditionally.
  - HOLD: accept → SETUP (back-to-back); else → IDLE.
- LD:
  - Loaded with captured data on entry to SETUP.
  - Held unchanged through SETUP, OPEN and HOLD.
  - Retains its last value in IDLE; it does not return to 0.
- LG:
  - All zero except in OPEN, where exactly bit addr is 1.
  - Driven from registers. Next-state logic computes the one-hot value; it is not decoded combinationally after the flops.
- Out-of-range address (WR_ADDR ≥ WORDS, possible only when WORDS is not a power of 2):
  - The request is accepted and the full SETUP/OPEN/HOLD sequence runs, but LG stays all zero.
  - ERR pulses high for exactly the SETUP cycle.
- Simultaneous events: acceptance in HOLD and the HOLD → SETUP move happen on the same edge. LD changes only on that edge, which is one full cycle after LG fell.
- Reset:
  - RST high immediately forces state=IDLE, LG=0, LD=0, ERR=0, regardless of CK. BUSY=0 and WR_READY=1 follow from state=IDLE.
  - An in-flight write interrupted by reset leaves the target latch contents undefined. This is the upstream agent's responsibility.
  - A request presented while RST is high is not accepted.
- Reset release: the first accepting edge is the first rising CK after RST falls.

## Timing
- Acceptance edge = E0.
- E0: state=SETUP, LD=data, LG=0.
- E1: state=OPEN, LG[addr]=1 (gate open for exactly one CK period).
- E2: state=HOLD, LG=0, LD unchanged.
- E3: IDLE, or SETUP of the next write.
- Latch setup margin is ≥1 CK period (LD valid one cycle before LG rises). Hold margin is ≥1 CK period (LD stable one cycle after LG falls).
- Sustained throughput is one write per 3 cycles. Accept-to-gate-open latency is 1 cycle. Accept-to-complete latency is 3 cycles.
- WR_READY is low in SETUP and OPEN; the upstream agent must hold WR_VALID, WR_ADDR and WR_DATA stable until accepted.
- No combinational path from any input to LD, LG, BUSY or ERR.

## Test plan
Defaults: WORDS=8, WIDTH=8 unless stated.
- Reset values: assert RST mid-cycle with no clock → LG=0x00, LD=0x00, BUSY=0, WR_READY=1, ERR=0 immediately.
- Single write: write 0xA5 to addr 3 from idle → LD=0xA5 at E0; LG=0x08 only between E1 and E2; back in IDLE after E3. A behavioural DLH_X2 bank reads word3=0xA5 and all other words unchanged.
- Back-to-back: hold WR_VALID high for addr 0/0x11, 7/0x77, 2/0x22 → accepts at cycles 0, 3, 6; LG pulses 0x01, 0x80, 0x04 at cycles 1, 4, 7; LD never changes while any LG bit is high; WR_READY low in the SETUP and OPEN cycles.
- Stall: WR_VALID high in the SETUP cycle with new addr/data → not accepted until HOLD; captured values are those present at the HOLD edge.
- Out-of-range: WORDS=6, write addr 6 → ERR high for the SETUP cycle only; LG=0 throughout; BUSY high for 3 cycles.
- Reset mid-operation: assert RST during OPEN → LG drops to 0 asynchronously; after release, the next write to addr 5 sequences normally from IDLE.
